bsg_cache_to_dram_ctrl_rx: RTL and testbench



---
 rtl/bsg_cache_to_dram_ctrl_pkg.sv | 29 ++
 rtl/bsg_cache_to_dram_ctrl_rx_fifo.sv | 65 ++++++
 rtl/bsg_cache_to_dram_ctrl_rx.sv | 110 +++++++++++
 tb/tb_bsg_cache_to_dram_ctrl_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_cache_to_dram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bsg_cache_to_dram_ctrl_pkg : width helpers and config legality shared by rx/tx
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bsg_cache_to_dram_ctrl_pkg;

   localparam int min_burst_len = 2;

   function automatic int beat_cnt_width(input int burst_len);
      return (burst_len > 1) ? $clog2(burst_len) : 1;
   endfunction

   function automatic int credit_width(input int fifo_els);
      return $clog2(fifo_els + 1);
   endfunction

   // burst_len must be a power of two so the beat counter wraps naturally
   function automatic bit cfg_legal(input int burst_len, input int fifo_els);
      return (burst_len >= min_burst_len)
          && ((burst_len & (burst_len - 1)) == 0)
          && (fifo_els >= burst_len)
          && ((fifo_els % burst_len) == 0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_cache_to_dram_ctrl_rx_fifo.sv
// ---------------------------------------------------------------------------
// bsg_cache_to_dram_ctrl_rx_fifo : 1r1w beat FIFO, wrap-bit pointers, no bypass
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_cache_to_dram_ctrl_rx_fifo #(
   parameter int width_p = 32,
   parameter int els_p   = 16
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               push_i,
   input  logic [width_p-1:0] data_i,
   input  logic               pop_i,
   output logic [width_p-1:0] data_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int idx_w = (els_p > 1) ? $clog2(els_p) : 1;
   localparam logic [idx_w-1:0] last_idx = idx_w'(els_p - 1);

   logic [width_p-1:0] mem [els_p];
   logic [idx_w-1:0]   wr_idx;
   logic [idx_w-1:0]   rd_idx;
   logic               wr_wrap;
   logic               rd_wrap;
   logic               do_push;
   logic               do_pop;

   assign empty_o = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
   assign full_o  = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
   assign do_pop  = pop_i & ~empty_o;
   // a pop in the same cycle frees the slot, so a push at full is still taken
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = mem[rd_idx];

   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_idx] <= data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         wr_idx  <= '0;
         rd_idx  <= '0;
         wr_wrap <= 1'b0;
         rd_wrap <= 1'b0;
      end else begin
         if (do_push) begin
            wr_idx  <= (wr_idx == last_idx) ? '0 : wr_idx + 1'b1;
            wr_wrap <= wr_wrap ^ (wr_idx == last_idx);
         end
         if (do_pop) begin
            rd_idx  <= (rd_idx == last_idx) ? '0 : rd_idx + 1'b1;
            rd_wrap <= rd_wrap ^ (rd_idx == last_idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/bsg_cache_to_dram_ctrl_rx.sv
// ---------------------------------------------------------------------------
// bsg_cache_to_dram_ctrl_rx : DRAM read-data return path with burst credits.
// Optional protocol checks: BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bsg_cache_to_dram_ctrl_rx
   import bsg_cache_to_dram_ctrl_pkg::*;
#(
   parameter int dma_data_width_p = 32,
   parameter int burst_len_p      = 8,
   parameter int fifo_els_p       = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic                        rd_cmd_v_i,
   output logic                        rd_cmd_ready_o,
   input  logic                        app_rd_data_valid_i,
   input  logic [dma_data_width_p-1:0] app_rd_data_i,
   input  logic                        app_rd_data_end_i,
   output logic [dma_data_width_p-1:0] dma_data_o,
   output logic                        dma_data_v_o,
   input  logic                        dma_data_ready_i,
   output logic                        protocol_err_o
);

   localparam int credit_w = credit_width(fifo_els_p);
   localparam logic [credit_w-1:0] burst_credit = credit_w'(burst_len_p);
   localparam logic [credit_w-1:0] full_credit  = credit_w'(fifo_els_p);

   logic [credit_w-1:0] credit;
   logic                cmd_accept;
   logic                pop;
   logic                fifo_empty;
   logic                fifo_full;

   bsg_cache_to_dram_ctrl_rx_fifo #(
      .width_p (dma_data_width_p),
      .els_p   (fifo_els_p)
   ) fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .push_i    (app_rd_data_valid_i),
      .data_i    (app_rd_data_i),
      .pop_i     (pop),
      .data_o    (dma_data_o),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   assign dma_data_v_o   = ~fifo_empty;
   assign pop            = dma_data_v_o & dma_data_ready_i;
   assign rd_cmd_ready_o = (credit >= burst_credit);
   assign cmd_accept     = rd_cmd_v_i & rd_cmd_ready_o;

   // credit saturates at full so stray pops cannot over-grant space
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         credit <= full_credit;
      end else if (cmd_accept) begin
         credit <= credit - burst_credit + credit_w'(pop);
      end else if (pop && (credit != full_credit)) begin
         credit <= credit + 1'b1;
      end
   end

`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN
   localparam int beat_w = beat_cnt_width(burst_len_p);
   localparam logic [beat_w-1:0] last_beat = beat_w'(burst_len_p - 1);

   logic [beat_w-1:0]   beat_cnt;
   logic [credit_w-1:0] outstanding;
   logic                err;
   logic                err_set;
   logic                at_last_beat;
   logic                burst_done;

   assign at_last_beat = (beat_cnt == last_beat);
   assign burst_done   = app_rd_data_valid_i & at_last_beat & (outstanding != '0);
   assign err_set      = app_rd_data_valid_i
                       & ((fifo_full & ~pop)
                        | (app_rd_data_end_i != at_last_beat)
                        | (outstanding == '0));

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         beat_cnt    <= '0;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         if (app_rd_data_valid_i) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (cmd_accept && !burst_done) begin
            outstanding <= outstanding + 1'b1;
         end else if (!cmd_accept && burst_done) begin
            outstanding <= outstanding - 1'b1;
         end
         err <= err | err_set;
      end
   end

   assign protocol_err_o = err;
`else
   assign protocol_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_cache_to_dram_ctrl_rx.sv
// Scoreboard bench for bsg_cache_to_dram_ctrl_rx: queue-based reference model,
// directed scenarios followed by randomized legal traffic.
`default_nettype none

module tb_bsg_cache_to_dram_ctrl_rx;

   localparam int W = 32;
   localparam int B = 8;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         cmd_v = 1'b0;
   logic         app_v = 1'b0;
   logic         app_end = 1'b0;
   logic [W-1:0] app_d = '0;
   logic         dready = 1'b0;
   logic         cmd_ready;
   logic [W-1:0] ddata;
   logic         dvalid;
   logic         perr;

   bsg_cache_to_dram_ctrl_rx #(
      .dma_data_width_p (W),
      .burst_len_p      (B),
      .fifo_els_p       (N)
   ) dut (
      .clk_i               (clk),
      .reset_n_i           (reset_n),
      .rd_cmd_v_i          (cmd_v),
      .rd_cmd_ready_o      (cmd_ready),
      .app_rd_data_valid_i (app_v),
      .app_rd_data_i       (app_d),
      .app_rd_data_end_i   (app_end),
      .dma_data_o          (ddata),
      .dma_data_v_o        (dvalid),
      .dma_data_ready_i    (dready),
      .protocol_err_o      (perr)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit mon_en = 1'b0;

   // reference model state: FIFO contents, free credit, error bookkeeping
   logic [W-1:0] exp_q[$];
   int m_credit = N;
   bit m_err = 1'b0;
   int m_beat = 0;
   int m_out = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin : model
      bit acc, pp, ovf;
      int out_old;
      if (!reset_n) begin
         exp_q.delete();
         m_credit = N;
         m_err = 1'b0;
         m_beat = 0;
         m_out = 0;
      end else begin
         acc = cmd_v && (m_credit >= B);
         pp = (exp_q.size() > 0) && dready;
         ovf = app_v && (exp_q.size() == N) && !pp;
         if (pp) void'(exp_q.pop_front());
         if (app_v && !ovf) exp_q.push_back(app_d);
         m_credit = m_credit - (acc ? B : 0) + (pp ? 1 : 0);
         if (m_credit > N) m_credit = N;
         if (m_credit < 0) m_credit = 0;
         out_old = m_out;
         if (app_v && (ovf || (app_end != (m_beat == B - 1)) || out_old == 0)) m_err = 1'b1;
         if (acc) m_out++;
         if (app_v && m_beat == B - 1 && out_old > 0) m_out--;
         if (app_v) m_beat = (m_beat + 1) % B;
      end
   end

   always @(negedge clk) begin : monitor
      bit exp_err;
      if (mon_en) begin
`ifdef BSG_CACHE_TO_DRAM_CTRL_RX_CHECK_EN
         exp_err = m_err;
`else
         exp_err = 1'b0;
`endif
         check("cmd_ready", 64'(cmd_ready), 64'(m_credit >= B));
         check("data_v", 64'(dvalid), 64'(exp_q.size() > 0));
         if (dvalid && exp_q.size() > 0) check("data", 64'(ddata), 64'(exp_q[0]));
         check("protocol_err", 64'(perr), 64'(exp_err));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [W-1:0] d, input bit e);
      app_v = 1'b1;
      app_d = d;
      app_end = e;
      tick();
      app_v = 1'b0;
      app_end = 1'b0;
   endtask

   task automatic cmds(input int n);
      cmd_v = 1'b1;
      repeat (n) tick();
      cmd_v = 1'b0;
   endtask

   task automatic drain(input bit toggle);
      int k;
      k = 0;
      dready = 1'b1;
      while (exp_q.size() > 0 && k < 200) begin
         tick();
         if (toggle) dready = ~dready;
         k++;
      end
      n_cmp++;
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain_timeout: got %0d beats left expected 0", exp_q.size());
      end
      dready = 1'b1;
      tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   initial begin
      int pending;
      bit acc;
      tick();
      tick();
      mon_en = 1'b1;
      reset_n = 1'b1;
      tick();
      tick();

      // two back-to-back commands plus one ignored while not ready
      cmds(3);
      for (int i = 0; i < 16; i++) beat($urandom, (i % B) == B - 1);
      dready = 1'b1;
      tick();
      dready = 1'b0;
      tick();
      tick();
      drain(1'b0);

      // one burst, full-rate drain
      cmds(1);
      for (int i = 0; i < B; i++) beat(32'hA0 + i, i == B - 1);
      drain(1'b0);

      // one burst, ready toggling
      cmds(1);
      for (int i = 0; i < B; i++) begin
         dready = (i % 2) == 0;
         beat(32'hA0 + i, i == B - 1);
      end
      drain(1'b1);

      // end flag on the 5th beat
      cmds(1);
      dready = 1'b0;
      for (int i = 0; i < B; i++) beat(32'hB0 + i, i == 4);
      tick();
      tick();
      drain(1'b0);
      do_reset();

      // 17 beats without pops: the last one is dropped
      dready = 1'b0;
      cmds(2);
      for (int i = 0; i < 17; i++) beat(32'hC00 + i, (i % B) == B - 1);
      tick();
      drain(1'b0);
      do_reset();

      // randomized legal traffic: beats only for already-accepted commands
      pending = 0;
      for (int c = 0; c < 600; c++) begin
         cmd_v = ($urandom % 4) == 0;
         dready = ($urandom % 3) != 0;
         acc = cmd_v && (m_credit >= B);
         if (pending > 0 && ($urandom % 4) != 0) begin
            app_v = 1'b1;
            app_d = $urandom;
            app_end = (pending % B) == 1;
            pending--;
         end else begin
            app_v = 1'b0;
            app_end = 1'b0;
         end
         if (acc) pending += B;
         tick();
      end
      cmd_v = 1'b0;
      while (pending > 0) begin
         app_v = 1'b1;
         app_d = $urandom;
         app_end = (pending % B) == 1;
         pending--;
         tick();
      end
      app_v = 1'b0;
      app_end = 1'b0;
      drain(1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
